// File: rtl/dvi_data_enc.sv
// rtl/dvi_data_enc.sv - DVI 1.0 TMDS data/control encoder, 2-stage pipeline
module dvi_data_enc (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] ch_in,
    input  logic       ch_de,
    output logic [9:0] ch_out
);

    localparam logic [9:0] CTL_SYM_00 = 10'b1101010100;
    localparam logic [9:0] CTL_SYM_01 = 10'b0010101011;
    localparam logic [9:0] CTL_SYM_10 = 10'b0101010100;
    localparam logic [9:0] CTL_SYM_11 = 10'b1010101011;

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, d[i]};
        end
        return c;
    endfunction

    // q[i] = d[0] ^ ... ^ d[i]; the XOR chain of the minimisation step
    function automatic logic [7:0] prefix_xor8(input logic [7:0] d);
        logic [7:0] q;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = q[i-1] ^ d[i];
        end
        return q;
    endfunction

    logic [7:0]        w_data;
    logic [1:0]        w_ctl;
    logic [3:0]        w_data_n1;
    logic              w_use_xnor;
    logic [8:0]        w_qm;

    logic              r_de0;
    logic [1:0]        r_ctl0;
    logic [8:0]        r_qm;
    logic signed [4:0] r_cnt;

    logic [3:0]        w_n1;
    logic signed [4:0] w_d10;
    logic signed [4:0] w_cnt_nxt;
    logic [9:0]        w_sym;

    assign w_data = ch_in[7:0];
    assign w_ctl  = ch_in[9:8];

    // Stage 0 transition minimisation; an XNOR chain equals the XOR chain with every odd bit inverted
    always_comb begin
        w_data_n1  = popcount8(w_data);
        w_use_xnor = (w_data_n1 > 4'd4) || ((w_data_n1 == 4'd4) && !w_data[0]);
        w_qm[7:0]  = prefix_xor8(w_data) ^ (w_use_xnor ? 8'b1010_1010 : 8'b0000_0000);
        w_qm[8]    = !w_use_xnor;
    end

    // Stage 0 pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_de0  <= 1'b0;
            r_ctl0 <= 2'b00;
            r_qm   <= 9'd0;
        end else begin
            r_de0  <= ch_de;
            r_ctl0 <= w_ctl;
            r_qm   <= w_qm;
        end
    end

    // Stage 1 DC balancing; w_d10 is n1-n0 = 2*n1-8, all sums stay in the signed 5-bit domain
    always_comb begin
        w_n1  = popcount8(r_qm[7:0]);
        w_d10 = $signed({w_n1, 1'b0}) - 5'sd8;
        if ((r_cnt == 5'sd0) || (w_n1 == 4'd4)) begin
            w_sym     = {!r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
            w_cnt_nxt = r_qm[8] ? (r_cnt + w_d10) : (r_cnt - w_d10);
        end else if ((!r_cnt[4] && (w_n1 > 4'd4)) || (r_cnt[4] && (w_n1 < 4'd4))) begin
            w_sym     = {1'b1, r_qm[8], ~r_qm[7:0]};
            w_cnt_nxt = r_cnt + (r_qm[8] ? 5'sd2 : 5'sd0) - w_d10;
        end else begin
            w_sym     = {1'b0, r_qm[8], r_qm[7:0]};
            w_cnt_nxt = r_cnt + w_d10 - (r_qm[8] ? 5'sd0 : 5'sd2);
        end
    end

    // Stage 1 output register and running disparity; control periods restart balance from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_out <= 10'h000;
            r_cnt  <= 5'sd0;
        end else if (r_de0) begin
            ch_out <= w_sym;
            r_cnt  <= w_cnt_nxt;
        end else begin
            r_cnt <= 5'sd0;
            case (r_ctl0)
                2'b00:   ch_out <= CTL_SYM_00;
                2'b01:   ch_out <= CTL_SYM_01;
                2'b10:   ch_out <= CTL_SYM_10;
                default: ch_out <= CTL_SYM_11;
            endcase
        end
    end

endmodule
